// File: rtl/uart_pkg.sv
// Shared constants for the UART echo buffer: mode codes, launch FSM states, ASCII case bounds.
// Constants only; no timing or backpressure of its own.
package uart_pkg;

  localparam logic [1:0] MODE_ECHO  = 2'd0;
  localparam logic [1:0] MODE_UPPER = 2'd1;
  localparam logic [1:0] MODE_HOLD  = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LAUNCH,
    ST_WAIT_BUSY,
    ST_WAIT_DONE
  } tx_state_e;

  localparam logic [7:0] ASCII_LOWER_A  = 8'h61;
  localparam logic [7:0] ASCII_LOWER_Z  = 8'h7A;
  localparam logic [7:0] ASCII_CASE_OFS = 8'h20;

  localparam int BUSY_TIMEOUT = 4;

  function automatic logic [7:0] to_upper(input logic [7:0] b);
    if (b >= ASCII_LOWER_A && b <= ASCII_LOWER_Z) begin
      return b - ASCII_CASE_OFS;
    end
    return b;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with synchronous flush; push/pop take effect on the clock edge, head is combinational.
// Backpressure: a push while full is dropped unless a pop happens in the same cycle; pop on empty is ignored.
module sync_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              push_i,
  input  logic [DATA_W-1:0] push_dat_i,
  input  logic              pop_i,
  output logic [DATA_W-1:0] pop_dat_o,
  output logic [CNT_W-1:0]  count_o,
  output logic              full_o,
  output logic              empty_o
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              wr_en, rd_en;

  assign empty_o   = (count_q == '0);
  assign full_o    = (count_q == CNT_W'(DEPTH));
  assign count_o   = count_q;
  assign pop_dat_o = mem_q[rd_ptr_q];

  // A pop frees the slot this cycle, so a push into a full FIFO still lands.
  assign rd_en = pop_i && !empty_o && !flush_i;
  assign wr_en = push_i && !flush_i && (!full_o || pop_i);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_en) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (rd_en) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (wr_en && !rd_en)      count_d = count_q + CNT_W'(1);
      else if (rd_en && !wr_en) count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en) mem_q[wr_ptr_q] <= push_dat_i;
  end

endmodule

// File: rtl/uart_echo_buffer.sv
// Buffers received UART bytes and replays them to the transmitter; o_tx_dr fires 3 cycles after i_rx_done when idle.
// Backpressure: the FSM launches only when the TX is idle and mode is not hold; bytes arriving into a full FIFO are dropped and flagged sticky.
module uart_echo_buffer
  import uart_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic [DATA_W-1:0] i_rx_data,
  input  logic              i_rx_done,
  output logic [DATA_W-1:0] o_tx_data,
  output logic              o_tx_dr,
  input  logic              i_tx_busy,
  input  logic [1:0]        i_mode,
  input  logic              i_flush,
  output logic [DATA_W-1:0] o_disp_byte,
  output logic [CNT_W-1:0]  o_count,
  output logic              o_empty,
  output logic              o_full,
  output logic              o_overflow
);

  localparam int TMO_W = $clog2(BUSY_TIMEOUT);

  tx_state_e         state_q, state_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic              rx_vld_q;
  logic [DATA_W-1:0] rx_dat_q;
  logic [DATA_W-1:0] tx_data_q;
  logic              overflow_q, overflow_d;
  logic [DATA_W-1:0] push_dat;
  logic [DATA_W-1:0] head_dat;
  logic              pop;
  logic              tx_dr;

  // The captured byte doubles as the display byte, so it updates even when later dropped.
  always_comb begin
    push_dat = rx_dat_q;
    if (DATA_W == 8 && i_mode == MODE_UPPER) begin
      push_dat = DATA_W'(to_upper(8'(rx_dat_q)));
    end
  end

  sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .CNT_W  (CNT_W)
  ) u_fifo (
    .clk_i      (i_clk),
    .rst_i      (i_reset),
    .flush_i    (i_flush),
    .push_i     (rx_vld_q),
    .push_dat_i (push_dat),
    .pop_i      (pop),
    .pop_dat_o  (head_dat),
    .count_o    (o_count),
    .full_o     (o_full),
    .empty_o    (o_empty)
  );

  always_comb begin
    state_d = state_q;
    tmo_d   = tmo_q;
    pop     = 1'b0;
    tx_dr   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!o_empty && !i_tx_busy && i_mode != MODE_HOLD) begin
          pop     = 1'b1;
          state_d = ST_LAUNCH;
        end
      end
      ST_LAUNCH: begin
        tx_dr   = 1'b1;
        tmo_d   = '0;
        state_d = ST_WAIT_BUSY;
      end
      ST_WAIT_BUSY: begin
        // A TX that never raises busy is assumed to have taken the byte.
        if (i_tx_busy)                                 state_d = ST_WAIT_DONE;
        else if (tmo_q == TMO_W'(BUSY_TIMEOUT - 1))    state_d = ST_IDLE;
        else                                           tmo_d   = tmo_q + TMO_W'(1);
      end
      ST_WAIT_DONE: begin
        if (!i_tx_busy) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    overflow_d = overflow_q;
    if (i_flush)                              overflow_d = 1'b0;
    else if (rx_vld_q && o_full && !pop)      overflow_d = 1'b1;
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q    <= ST_IDLE;
      tmo_q      <= '0;
      rx_vld_q   <= 1'b0;
      rx_dat_q   <= '0;
      tx_data_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      tmo_q      <= tmo_d;
      rx_vld_q   <= i_rx_done;
      overflow_q <= overflow_d;
      if (i_rx_done) rx_dat_q  <= i_rx_data;
      if (pop)       tx_data_q <= head_dat;
    end
  end

  assign o_tx_data   = tx_data_q;
  assign o_tx_dr     = tx_dr;
  assign o_disp_byte = rx_dat_q;
  assign o_overflow  = overflow_q;

endmodule

// File: tb/tb_uart_echo_buffer.sv
// Randomised scoreboard bench for uart_echo_buffer with a simple busy-handshake TX model.
module tb_uart_echo_buffer;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 16;
  localparam int CNT_W  = $clog2(DEPTH + 1);

  typedef logic [7:0] bq_t [$];

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [DATA_W-1:0] rx_data = '0;
  logic              rx_done = 1'b0;
  logic              tx_busy;
  logic [1:0]        mode = 2'd0;
  logic              flush = 1'b0;
  logic [DATA_W-1:0] tx_data;
  logic              tx_dr;
  logic [DATA_W-1:0] disp_byte;
  logic [CNT_W-1:0]  count;
  logic              empty, full, overflow;

  uart_echo_buffer #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .i_clk       (clk),
    .i_reset     (rst),
    .i_rx_data   (rx_data),
    .i_rx_done   (rx_done),
    .o_tx_data   (tx_data),
    .o_tx_dr     (tx_dr),
    .i_tx_busy   (tx_busy),
    .i_mode      (mode),
    .i_flush     (flush),
    .o_disp_byte (disp_byte),
    .o_count     (count),
    .o_empty     (empty),
    .o_full      (full),
    .o_overflow  (overflow)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  int cyc = 0, dr_count = 0, last_dr_cyc = 0, last_rx_cyc = 0;
  int busy_len = 10;
  bit tx_never_busy = 1'b0;
  logic [7:0] exp_q [$];
  int dr_cycs [$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Spec rule: in uppercase mode, lower-case ASCII letters move down by 0x20.
  function automatic logic [7:0] model_xform(input logic [7:0] b, input logic [1:0] m);
    if (m == 2'd1 && b >= 8'h61 && b <= 8'h7A) return b - 8'h20;
    return b;
  endfunction

  // Transmitter model: busy rises the cycle after dr and stays for busy_len cycles.
  initial begin
    tx_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst && tx_dr && !tx_never_busy) begin
        @(posedge clk); #1 tx_busy = 1'b1;
        repeat (busy_len) @(posedge clk);
        #1 tx_busy = 1'b0;
      end
    end
  end

  // Monitor: every launch must match the oldest outstanding expected byte.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && tx_dr) begin
        dr_count++;
        last_dr_cyc = cyc;
        dr_cycs.push_back(cyc);
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_launch actual=0x%0h required=no_launch", tx_data);
        end else begin
          chk("tx_data", tx_data, exp_q.pop_front());
        end
      end
    end
  end

  task automatic send_seq(input bq_t bs, input int max_gap);
    foreach (bs[i]) begin
      int g;
      @(posedge clk); #1;
      rx_data = bs[i];
      rx_done = 1'b1;
      last_rx_cyc = cyc;
      g = $urandom_range(max_gap, 0);
      if (g > 0) begin
        @(posedge clk); #1 rx_done = 1'b0;
        repeat (g - 1) @(posedge clk);
      end
    end
    @(posedge clk); #1 rx_done = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || !empty || tx_busy) && n < budget) begin
      @(posedge clk); n++;
    end
    repeat (8) @(posedge clk);
    #1;
    checks++;
    if (n >= budget) begin
      failures++;
      $display("FAIL %s_drain actual=pending_%0d required=drained", name, exp_q.size());
    end
  endtask

  task automatic pulse_flush();
    @(posedge clk); #1 flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    bq_t bs;
    int d0, n;
    logic [1:0] m;

    // Reset values.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_tx_dr", tx_dr, 0);
    chk("rst_disp", disp_byte, 0);
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_overflow", overflow, 0);
    @(posedge clk); #1 rst = 1'b0;

    // Single byte, echo mode: latency and handshake.
    mode = 2'd0;
    d0 = dr_count;
    exp_q.push_back(8'h41);
    bs = '{8'h41};
    send_seq(bs, 0);
    wait_idle("single", 200);
    chk("single_latency", last_dr_cyc - last_rx_cyc, 3);
    chk("single_dr_pulses", dr_count - d0, 1);
    chk("single_disp", disp_byte, 8'h41);
    chk("single_count", count, 0);

    // Uppercase burst.
    mode = 2'd1;
    d0 = dr_count;
    bs = '{8'h61, 8'h7A, 8'h5B, 8'h7B};
    foreach (bs[i]) exp_q.push_back(model_xform(bs[i], mode));
    send_seq(bs, 0);
    wait_idle("upper", 400);
    chk("upper_dr_pulses", dr_count - d0, 4);
    chk("upper_disp", disp_byte, 8'h7B);

    // Hold mode: fill past capacity, then release.
    mode = 2'd2;
    d0 = dr_count;
    bs = {};
    for (int i = 0; i < DEPTH + 1; i++) bs.push_back(8'(i));
    send_seq(bs, 0);
    repeat (4) @(posedge clk); #1;
    chk("hold_no_dr", dr_count - d0, 0);
    chk("hold_full", full, 1);
    chk("hold_count", count, DEPTH);
    chk("hold_overflow", overflow, 1);
    chk("hold_disp", disp_byte, 8'h10);
    for (int i = 0; i < DEPTH; i++) exp_q.push_back(8'(i));
    mode = 2'd0;
    wait_idle("release", 1000);
    chk("release_dr_pulses", dr_count - d0, DEPTH);
    chk("release_empty", empty, 1);
    chk("release_overflow_sticky", overflow, 1);

    // Push into a full FIFO on the same cycle as the IDLE pop.
    pulse_flush();
    #1;
    chk("flush_clears_overflow", overflow, 0);
    mode = 2'd2;
    d0 = dr_count;
    bs = {};
    for (int i = 0; i < DEPTH; i++) bs.push_back(8'(8'h20 + i));
    send_seq(bs, 0);
    repeat (2) @(posedge clk); #1;
    chk("coinc_full", full, 1);
    foreach (bs[i]) exp_q.push_back(bs[i]);
    exp_q.push_back(8'h99);
    @(posedge clk); #1 rx_data = 8'h99; rx_done = 1'b1;
    @(posedge clk); #1 rx_done = 1'b0; mode = 2'd0;
    wait_idle("coinc", 1000);
    chk("coinc_overflow", overflow, 0);
    chk("coinc_dr_pulses", dr_count - d0, DEPTH + 1);

    // Flush with one byte in flight and five queued.
    d0 = dr_count;
    bs = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5};
    exp_q.push_back(8'hA0);
    send_seq(bs, 0);
    @(posedge clk); #1;
    chk("flush_pre_count", count, 5);
    chk("flush_pre_busy", tx_busy, 1);
    exp_q.delete();
    pulse_flush();
    #1;
    chk("flush_count", count, 0);
    wait_idle("flush", 200);
    chk("flush_dr_pulses", dr_count - d0, 1);
    chk("flush_overflow", overflow, 0);
    chk("flush_post_count", count, 0);

    // TX that never goes busy: timeout returns to IDLE and relaunches.
    tx_never_busy = 1'b1;
    dr_cycs.delete();
    bs = '{8'h11, 8'h22, 8'h33};
    foreach (bs[i]) exp_q.push_back(bs[i]);
    send_seq(bs, 0);
    wait_idle("timeout", 200);
    chk("timeout_launches", dr_cycs.size(), 3);
    if (dr_cycs.size() == 3) begin
      chk("timeout_gap1", dr_cycs[1] - dr_cycs[0], 6);
      chk("timeout_gap2", dr_cycs[2] - dr_cycs[1], 6);
    end
    tx_never_busy = 1'b0;

    // Asynchronous reset mid WAIT_DONE.
    busy_len = 10;
    bs = '{8'h51, 8'h52, 8'h53};
    foreach (bs[i]) exp_q.push_back(bs[i]);
    send_seq(bs, 0);
    n = 0;
    while (!tx_busy && n < 50) begin @(posedge clk); n++; end
    chk("rst_mid_busy_seen", tx_busy, 1);
    repeat (2) @(posedge clk);
    @(negedge clk); #2;
    exp_q.delete();
    rst = 1'b1;
    #1;
    chk("arst_tx_data", tx_data, 0);
    chk("arst_tx_dr", tx_dr, 0);
    chk("arst_disp", disp_byte, 0);
    chk("arst_count", count, 0);
    chk("arst_empty", empty, 1);
    chk("arst_full", full, 0);
    chk("arst_overflow", overflow, 0);
    @(posedge clk); #1 rst = 1'b0;
    wait_idle("after_rst", 100);

    // Randomised rounds in echo / uppercase modes, bursts within depth.
    for (int r = 0; r < 8; r++) begin
      m = 2'($urandom_range(1, 0));
      mode = m;
      busy_len = $urandom_range(12, 1);
      n = $urandom_range(8, 1);
      d0 = dr_count;
      bs = {};
      for (int i = 0; i < n; i++) bs.push_back(8'($urandom_range(255, 0)));
      foreach (bs[i]) exp_q.push_back(model_xform(bs[i], m));
      send_seq(bs, 2);
      wait_idle("random", 600);
      chk("random_dr_pulses", dr_count - d0, n);
      chk("random_disp", disp_byte, bs[n-1]);
      chk("random_overflow", overflow, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_echo_buffer.md
Name: uart_echo_buffer

Overview:
- Buffered, mode-selectable replacement for the direct RX-to-TX loopback path in the UART bring-up top.
- Received bytes go into a parametrised FIFO. A launch FSM drains the FIFO into the UART transmitter one byte at a time, using the transmitter's data-ready/busy handshake.
- Bursts faster than the TX can drain are no longer lost.
- The block also supplies the last received byte to the seven-segment decoders, plus FIFO status.

Parameters:
- DATA_W, 8, byte width. Uppercase mode applies only when DATA_W == 8.
- DEPTH, 16, FIFO depth in entries. Must be a power of 2 and >= 2.
- CNT_W, $clog2(DEPTH+1), width of the occupancy count (derived).

Ports:
- i_clk  in  1  system clock
- i_reset  in  1  asynchronous reset, active-high
- i_rx_data  in  DATA_W  byte from the UART receiver
- i_rx_done  in  1  one-cycle strobe: i_rx_data is valid
- o_tx_data  out  DATA_W  byte presented to the UART transmitter
- o_tx_dr  out  1  one-cycle start strobe to the transmitter
- i_tx_busy  in  1  transmitter busy flag
- i_mode  in  2  0 = echo, 1 = uppercase echo, 2 = hold (buffer only), 3 = echo
- i_flush  in  1  synchronous FIFO clear
- o_disp_byte  out  DATA_W  last received byte, for the display decoders
- o_count  out  CNT_W  FIFO occupancy
- o_empty  out  1  o_count == 0
- o_full  out  1  o_count == DEPTH
- o_overflow  out  1  sticky: a byte was dropped because the FIFO was full

Behaviour:
- Reset values: o_tx_data = 0, o_tx_dr = 0, o_disp_byte = 0, o_count = 0, o_empty = 1, o_full = 0, o_overflow = 0. FSM goes to IDLE; read and write pointers go to 0.
- Write path:
  - On i_rx_done, o_disp_byte <= i_rx_data next cycle, in every mode, including when the byte is dropped.
  - The byte is pushed if the FIFO is not full, or if a pop occurs in the same cycle.
  - Otherwise the byte is dropped and o_overflow is set.
- Transform: in mode 1, bytes 0x61..0x7A are stored as value - 0x20. All other bytes, and all other modes, are stored unchanged. The transform is applied at push time.
- Pointers are log2(DEPTH) bits and wrap naturally. Full and empty are derived from o_count, not from pointer compare.
- FSM states:
  - IDLE: if !o_empty && !i_tx_busy && i_mode != 2, go to LAUNCH. Pop the head into o_tx_data in the same cycle.
  - LAUNCH: o_tx_dr = 1 for exactly this one cycle. Go to WAIT_BUSY.
  - WAIT_BUSY: wait for i_tx_busy == 1, then go to WAIT_DONE. If busy has not been seen after 4 cycles, treat the byte as sent and go to IDLE.
  - WAIT_DONE: wait for i_tx_busy == 0, then go to IDLE.
- Latency: a byte arriving into an empty FIFO with TX idle produces o_tx_dr 3 cycles after i_rx_done (push, then IDLE pop, then LAUNCH).
- Mode 2 (hold): blocks only new launches from IDLE. A transfer already in flight completes. Switching back to mode 0/1 resumes draining in FIFO order.
- Simultaneous push and pop: o_count is unchanged. This is allowed even when full.
- i_flush:
  - Clears the pointers, o_count and o_overflow.
  - A push in the same cycle is discarded.
  - The FSM is not interrupted: a byte already popped into o_tx_data completes normally.
- o_tx_data holds its value between launches.
- Reset mid-transfer: everything returns to reset values immediately. The downstream transmitter is reset by the same signal.

Decomposition:
- Shared package uart_pkg:
  - mode encodings MODE_ECHO / MODE_UPPER / MODE_HOLD
  - FSM state encoding
  - ASCII constants 0x61, 0x7A, 0x20
  - WAIT_BUSY timeout constant of 4
- One sub-module: sync_fifo (parametrised DATA_W/DEPTH; push, pop, flush, count, full, empty). The FSM and transform stay in the top of this block.

Test Plan:
- Mode 0, single byte 0x41, TX model that asserts busy 1 cycle after dr for 10 cycles: exactly one o_tx_dr pulse, 3 cycles after i_rx_done, with o_tx_data = 0x41. o_disp_byte = 0x41; o_count returns to 0.
- Mode 1, bytes 0x61, 0x7A, 0x5B, 0x7B sent back-to-back: transmitted 0x41, 0x5A, 0x5B, 0x7B in order. o_disp_byte ends at 0x7B.
- Mode 2 with DEPTH = 16: send 17 bytes 0x00..0x10. No o_tx_dr; o_full = 1; o_count = 16; o_overflow = 1; o_disp_byte = 0x10. Then switch to mode 0: transmitted 0x00..0x0F, o_empty = 1, o_overflow still 1.
- Full FIFO with i_rx_done coinciding with the IDLE pop cycle: the byte is accepted and o_overflow stays 0.
- Pulse i_flush with 5 bytes queued and one in flight: the in-flight byte completes; no further o_tx_dr; o_count = 0; o_overflow = 0.
- TX model that never asserts busy: FSM returns to IDLE after the 4-cycle timeout and launches the next queued byte. Assert i_reset mid-WAIT_DONE: all outputs take reset values asynchronously.
